// File: rtl/mmio_initiator.sv
// mmio_initiator: turns a valid/ready command stream into single mem_valid/mem_ready bus transactions.
// Latency: command accept to rsp_valid is 2 cycles with a 1-cycle responder; at most one transaction per 4 cycles.
// Backpressure: cmd_ready only in IDLE; a response is held in RESP until rsp_ready. Timeout abort: MMIO_INITIATOR_TIMEOUT_EN.
module mmio_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  // Counter width and terminal count are only meaningful for 1..65535.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mmio_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

`ifdef MMIO_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             expire;

  // The edge that would bring the counter to TIMEOUT_CYCLES is the abort edge,
  // so mem_valid stays high for exactly TIMEOUT_CYCLES cycles.
  assign expire = (cnt_q >= CNT_LAST);
`endif

  // Next-state and next-output logic; every registered output defaults to hold.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          mem_addr_d  = cmd_addr;
          mem_wdata_d = cmd_wdata;
          mem_wstrb_d = cmd_wstrb;
          mem_valid_d = 1'b1;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = BUS;
        end
      end
      BUS: begin
        // A completion on the terminal-count edge still counts as success.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = (mem_wstrb_q == 4'h0) ? mem_rdata : 32'h0;
          rsp_valid_d = 1'b1;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef MMIO_INITIATOR_TIMEOUT_EN
        else if (expire) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cnt_d       = CNT_MAX;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        // Late acks from an aborted responder land here and are ignored.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // Registered ready: RESP->IDLE plus one IDLE cycle keeps mem_valid low for >= 2 cycles.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MMIO_INITIATOR_TIMEOUT_EN
  // Timeout counter and error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_instr = 1'b0;

endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: directed bench for mmio_initiator against a small timer-like responder.
// Latency: responder acks one cycle after it samples mem_valid (registered pulse).
// Backpressure: rsp_ready driven explicitly by each sequence.
module tb_mmio_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  // Timer-like responder: 0x7000 data reg, 0x7004 compare reg (resets to all ones), 0x7008 free-running tick.
  logic        ack_q;
  logic        resp_en;
  logic        inject;
  logic [31:0] inj_rdata;
  logic [31:0] rdata_q;
  logic [31:0] reg0;
  logic [31:0] reg1;
  logic [31:0] tick;

  assign mem_ready = (ack_q & resp_en) | inject;
  assign mem_rdata = inject ? inj_rdata : rdata_q;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      reg0    <= 32'h0;
      reg1    <= 32'hFFFF_FFFF;
      tick    <= 32'h0;
    end else begin
      tick  <= tick + 32'd1;
      ack_q <= 1'b0;
      if (mem_valid && !ack_q && resp_en) begin
        ack_q <= 1'b1;
        case (mem_addr)
          32'h8100_7000: rdata_q <= reg0;
          32'h8100_7004: rdata_q <= reg1;
          32'h8100_7008: rdata_q <= tick;
          default:       rdata_q <= 32'h0;
        endcase
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) begin
            if (mem_addr == 32'h8100_7000) reg0[8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_addr == 32'h8100_7004) reg1[8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Shortest run of mem_valid-low cycles between two requests (reset breaks the run).
  int low_run = 1000;
  int min_gap = 1000;
  always @(negedge clk) begin
    if (!resetn) begin
      low_run <= 1000;
    end else if (mem_valid) begin
      if (low_run > 0 && low_run < min_gap) min_gap <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  // Offer one command and wait (bounded) until it is accepted; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
  endtask

  // One complete transaction with latency, bus-stability and response checks.
  task automatic do_txn(input vec_t v);
    int hi;
    int lat;
    logic stable;
    issue(v.addr, v.wdata, v.wstrb);
    hi = 0;
    lat = 0;
    stable = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if (mem_valid) hi++;
      if (mem_addr !== v.addr || mem_wdata !== v.wdata || mem_wstrb !== v.wstrb ||
          cmd_ready !== 1'b0 || mem_instr !== 1'b0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'd2);
    chk("mem_valid_cycles", 32'(hi), 32'd2);
    chk("bus_stable", {31'h0, stable}, 32'h1);
    chk("mem_valid_drop", {31'h0, mem_valid}, 32'h0);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'h0, rsp_err}, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_consumed", {31'h0, rsp_valid}, 32'h0);
    chk("idle_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    int n;
    logic ok;
    int acc_t[4];
    logic [31:0] rsp_d[4];
    int n_acc;
    int n_rsp;
    int cyc;
    int hi;

    vecs[0] = '{32'h8100_7000, 32'h0000_0005, 4'hF, 32'h0000_0000};
    vecs[1] = '{32'h8100_7000, 32'h0000_0000, 4'h0, 32'h0000_0005};
    vecs[2] = '{32'h8100_7004, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF};
    vecs[3] = '{32'h8100_7000, 32'hAABB_CCDD, 4'h5, 32'h0000_0000};
    vecs[4] = '{32'h8100_7000, 32'h0000_0000, 4'h0, 32'h00BB_00DD};
    vecs[5] = '{32'h8100_7004, 32'h1234_5678, 4'hC, 32'h0000_0000};
    vecs[6] = '{32'h8100_7004, 32'h0000_0000, 4'h0, 32'h1234_FFFF};
    vecs[7] = '{32'h8100_7000, 32'h0000_9900, 4'h2, 32'h0000_0000};
    vecs[8] = '{32'h8100_7000, 32'h0000_0000, 4'h0, 32'h00BB_99DD};

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    resp_en   = 1'b1;
    inject    = 1'b0;
    inj_rdata = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mem_instr", {31'h0, mem_instr}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    resetn = 1'b1;
    #1;
    chk("ready_before_edge", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("ready_first_edge", {31'h0, cmd_ready}, 32'h1);

    // Table of single transactions.
    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Response backpressure with a second command already waiting.
    issue(32'h8100_7004, 32'h0, 4'h0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h8100_7000;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rdata", rsp_rdata, 32'h1234_FFFF);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || mem_valid !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_rdata !== 32'h1234_FFFF || rsp_err !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold", {31'h0, ok}, 32'h1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle_ready", {31'h0, cmd_ready}, 32'h1);
    chk("bp_idle_mem_valid", {31'h0, mem_valid}, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("bp_next_addr", mem_addr, 32'h8100_7000);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_rdata", rsp_rdata, 32'h00BB_99DD);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Back-to-back reads of the free-running tick.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h8100_7008;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    cyc = 0;
    while ((n_acc < 4 || n_rsp < 4) && cyc < 60) begin
      if (n_acc == 4) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready && n_acc < 4) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (rsp_valid && rsp_ready && n_rsp < 4) begin
        rsp_d[n_rsp] = rsp_rdata;
        n_rsp++;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_responses", 32'(n_rsp), 32'd4);
    for (int i = 1; i < 4; i++) begin
      chk("b2b_accept_interval", 32'(acc_t[i] - acc_t[i-1]), 32'd4);
      chk("b2b_tick_delta", rsp_d[i] - rsp_d[i-1], 32'd4);
    end

    // Silent responder: timeout abort, or indefinite wait when the timeout is not built.
    resp_en = 1'b0;
    issue(32'h8100_7000, 32'h0, 4'h0);
`ifdef MMIO_INITIATOR_TIMEOUT_EN
    hi = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (mem_valid) hi++;
      @(negedge clk);
      n++;
    end
    chk("to_mem_valid_cycles", 32'(hi), 32'(TO));
    chk("to_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("to_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_mem_valid_low", {31'h0, mem_valid}, 32'h0);
    inject    = 1'b1;
    inj_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    inject = 1'b0;
    chk("to_late_ack_valid", {31'h0, rsp_valid}, 32'h1);
    chk("to_late_ack_err", {31'h0, rsp_err}, 32'h1);
    chk("to_late_ack_rdata", rsp_rdata, 32'h0);
    chk("to_late_ack_mem_valid", {31'h0, mem_valid}, 32'h0);
`else
    hi = 0;
    ok = 1'b1;
    repeat (20) begin
      if (!mem_valid || rsp_valid || rsp_err) ok = 1'b0;
      @(negedge clk);
    end
    chk("wait_holds_bus", {31'h0, ok}, 32'h1);
    inject    = 1'b1;
    inj_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    inject    = 1'b0;
    chk("slow_ack_valid", {31'h0, rsp_valid}, 32'h1);
    chk("slow_ack_rdata", rsp_rdata, 32'h5A5A_5A5A);
    chk("slow_ack_err", {31'h0, rsp_err}, 32'h0);
    chk("slow_ack_mem_valid", {31'h0, mem_valid}, 32'h0);
    inject    = 1'b1;
    inj_rdata = 32'h0;
    @(negedge clk);
    inject = 1'b0;
    chk("resp_ignores_ack_rdata", rsp_rdata, 32'h5A5A_5A5A);
    chk("resp_ignores_ack_valid", {31'h0, rsp_valid}, 32'h1);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("abort_consumed", {31'h0, rsp_valid}, 32'h0);
    resp_en = 1'b1;
    do_txn(vecs[8]);

    // Reset while a request is on the bus.
    resp_en = 1'b0;
    issue(32'h8100_7000, 32'h0, 4'h0);
    chk("mid_in_bus", {31'h0, mem_valid}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_async_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("mid_async_mem_addr", mem_addr, 32'h0);
    chk("mid_async_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    repeat (2) @(negedge clk);
    resp_en = 1'b1;
    resetn  = 1'b1;
    #1;
    chk("mid_release_ready", {31'h0, cmd_ready}, 32'h0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) ok = 1'b0;
    end
    chk("mid_no_response", {31'h0, ok}, 32'h1);
    chk("mid_ready_after_edge", {31'h0, cmd_ready}, 32'h1);

    chk("min_idle_gap_ge2", {31'h0, (min_gap >= 2)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
